// File: rtl/alu_pipe_unit_if.sv
// Request/response bundle between issue logic and the ALU execution unit.
// Latency: n/a (wiring only).
// Backpressure: req_ready / rsp_ready valid-ready pairs on each channel.
interface alu_pipe_unit_if #(
    parameter int XLEN = 32,
    parameter int OP_W = 6
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [OP_W-1:0] alu_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic            overflow;
    logic            illegal_op;
    logic            busy;

    // Issue side: produces requests, consumes responses.
    modport master (
        output req_valid, operand_a, operand_b, alu_op, rsp_ready,
        input  req_ready, rsp_valid, alu_result, zero, overflow, illegal_op, busy
    );

    // ALU side: consumes requests, produces responses.
    modport slave (
        input  req_valid, operand_a, operand_b, alu_op, rsp_ready,
        output req_ready, rsp_valid, alu_result, zero, overflow, illegal_op, busy
    );
endinterface

// File: rtl/alu_pipe_unit.sv
// Two-stage pipelined ALU: S1 holds latched operands, S2 holds result and flags.
// Latency: request accepted at edge N gives rsp_valid after edge N+1; 1 op/cycle.
// Backpressure: rsp_ready low stalls S2, then S1; req_ready drops once both are full.
module alu_pipe_unit #(
    parameter int XLEN    = 32,
    parameter int OP_W    = 6,
    parameter int SHAMT_W = 5
) (
    input logic           clk,
    input logic           rst_n,
    alu_pipe_unit_if.slave bus
);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000110);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b000111);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(6'b001011);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(6'b001101);

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } s1_dat_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic            overflow;
        logic            illegal;
    } s2_dat_t;

    logic    s1_valid_q, s1_valid_d;
    logic    s2_valid_q, s2_valid_d;
    s1_dat_t s1_dat_q,   s1_dat_d;
    s2_dat_t s2_dat_q,   s2_dat_d;

    logic    s2_free;
    logic    accept;
    logic    advance;
    s2_dat_t exe_dat;

    // Handshake and pipeline advance: S2 frees when empty or being drained.
    always_comb begin
        s2_free       = !s2_valid_q || bus.rsp_ready;
        advance       = s1_valid_q && s2_free;
        bus.req_ready = !s1_valid_q || s2_free;
        accept        = bus.req_valid && bus.req_ready;
    end

    // Execute: result and flags from the S1 registers.
    always_comb begin
        logic [XLEN-1:0]    sum;
        logic [XLEN-1:0]    diff;
        logic [SHAMT_W-1:0] shamt;
        sum              = s1_dat_q.a + s1_dat_q.b;
        diff             = s1_dat_q.a - s1_dat_q.b;
        shamt            = s1_dat_q.b[SHAMT_W-1:0];
        exe_dat          = '0;
        case (s1_dat_q.op)
            OP_ADD: begin
                exe_dat.result   = sum;
                // Same-sign operands producing an opposite-sign sum.
                exe_dat.overflow = (s1_dat_q.a[XLEN-1] == s1_dat_q.b[XLEN-1]) &&
                                   (sum[XLEN-1] != s1_dat_q.a[XLEN-1]);
            end
            OP_SUB: begin
                exe_dat.result   = diff;
                // Opposite-sign operands where the difference flips a's sign.
                exe_dat.overflow = (s1_dat_q.a[XLEN-1] != s1_dat_q.b[XLEN-1]) &&
                                   (diff[XLEN-1] != s1_dat_q.a[XLEN-1]);
            end
            OP_AND:  exe_dat.result = s1_dat_q.a & s1_dat_q.b;
            OP_OR:   exe_dat.result = s1_dat_q.a | s1_dat_q.b;
            OP_XOR:  exe_dat.result = s1_dat_q.a ^ s1_dat_q.b;
            OP_SLL:  exe_dat.result = s1_dat_q.a << shamt;
            OP_SRL:  exe_dat.result = s1_dat_q.a >> shamt;
            OP_SRA:  exe_dat.result = $unsigned($signed(s1_dat_q.a) >>> shamt);
            OP_SLT:  exe_dat.result = XLEN'($signed(s1_dat_q.a) < $signed(s1_dat_q.b));
            OP_SLTU: exe_dat.result = XLEN'(s1_dat_q.a < s1_dat_q.b);
            default: exe_dat.illegal = 1'b1;
        endcase
        exe_dat.zero = (exe_dat.result == '0);
    end

    // Next-state: S1 data loads only on accept; S2 data only on advance.
    always_comb begin
        s1_dat_d   = s1_dat_q;
        s2_dat_d   = s2_dat_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (accept) begin
            s1_dat_d.op = bus.alu_op;
            s1_dat_d.a  = bus.operand_a;
            s1_dat_d.b  = bus.operand_b;
        end
        if (advance) begin
            s2_dat_d = exe_dat;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end
        if (advance) begin
            s2_valid_d = 1'b1;
        end else if (bus.rsp_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_dat_q   <= '0;
            s2_dat_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_dat_q   <= s1_dat_d;
            s2_dat_q   <= s2_dat_d;
        end
    end

    // Response outputs come straight from the S2 registers.
    always_comb begin
        bus.rsp_valid  = s2_valid_q;
        bus.alu_result = s2_dat_q.result;
        bus.zero       = s2_dat_q.zero;
        bus.overflow   = s2_dat_q.overflow;
        bus.illegal_op = s2_dat_q.illegal;
        bus.busy       = s1_valid_q || s2_valid_q;
    end

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Directed bench for alu_pipe_unit with a queue scoreboard of expected responses.
// Latency: checks accept-to-response spacing while rsp_ready stays high.
// Backpressure: exercises stall, refill and async reset with ops in flight.
module tb_alu_pipe_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_pipe_unit_if #(.XLEN(32), .OP_W(6)) bus ();

    alu_pipe_unit #(.XLEN(32), .OP_W(6), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        i;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    bit   last_acc = 1'b0;
    bit   chk_lat  = 1'b0;

    // Reference model built from wide signed arithmetic rather than bit tricks.
    function automatic exp_t model(logic [5:0] op, logic [31:0] a, logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb_l;
        longint s;
        logic [31:0] r;
        sa   = longint'($signed(a));
        sb_l = longint'($signed(b));
        e.o  = 1'b0;
        e.i  = 1'b0;
        r    = 32'h0;
        case (op)
            6'b000010: begin s = sa + sb_l; r = a + b; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            6'b000110: begin s = sa - sb_l; r = a - b; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            6'b000111: r = a & b;
            6'b000101: r = a | b;
            6'b001000: r = a ^ b;
            6'b000100: r = a << b[4:0];
            6'b000011: r = a >> b[4:0];
            6'b001011: begin
                r = a;
                for (int k = 0; k < 32; k++) if (k < int'(b[4:0])) r = {a[31], r[31:1]};
            end
            6'b001100: r = (sa < sb_l) ? 32'd1 : 32'd0;
            6'b001101: r = (a < b) ? 32'd1 : 32'd0;
            default:   e.i = 1'b1;
        endcase
        e.res = r;
        e.z   = (r == 32'h0);
        e.acc = 0;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the negedge, then step past the posedge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        last_acc = bus.req_valid && bus.req_ready;
        if (last_acc) begin
            e     = model(bus.alu_op, bus.operand_a, bus.operand_b);
            e.acc = cyc;
            sb.push_back(e);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("stale_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result",   bus.alu_result, e.res);
                chk("flags",    {29'd0, bus.zero, bus.overflow, bus.illegal_op}, {29'd0, e.z, e.o, e.i});
                // Accept sampled before edge N, response sampled after edge N+1.
                if (chk_lat) chk("latency", 32'(cyc - e.acc), 32'd2);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(logic [5:0] op, logic [31:0] a, logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.alu_op    = op;
        bus.operand_a = a;
        bus.operand_b = b;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (last_acc) break;
        end
        if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.alu_op    = 6'h0;
        bus.operand_a = 32'h0;
        bus.operand_b = 32'h0;
    endtask

    task automatic drain();
        idle();
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (sb.size() == 0 && !bus.rsp_valid) break;
            cycle();
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("drain_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    task automatic chk_idle_outputs(string tag);
        chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        chk({tag, "_result"},    bus.alu_result, 32'd0);
        chk({tag, "_flags"},     {29'd0, bus.zero, bus.overflow, bus.illegal_op}, 32'd0);
        chk({tag, "_busy"},      {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.rsp_ready = 1'b1;
        idle();
        #12;
        chk_idle_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle_outputs("after_reset");

        // 1: back-to-back stream
        chk_lat = 1'b1;
        send(6'b000010, 32'd100, 32'd50);
        send(6'b000110, 32'd100, 32'd50);
        send(6'b000111, 32'hFFFF0000, 32'h0000FFFF);
        send(6'b000101, 32'hFFFF0000, 32'h0000FFFF);
        drain();

        // 2: corner arithmetic
        send(6'b000010, 32'h7FFFFFFF, 32'd1);
        send(6'b000110, 32'd0, 32'd1);
        send(6'b001100, 32'h80000000, 32'd1);
        send(6'b001101, 32'h80000000, 32'd1);
        // 3: shifts
        send(6'b000100, 32'd1, 32'd5);
        send(6'b000011, 32'h20, 32'd5);
        send(6'b001011, 32'h80000000, 32'd4);
        send(6'b000100, 32'd1, 32'h00000025);
        drain();
        chk_lat = 1'b0;

        // 4: backpressure
        bus.rsp_ready = 1'b0;
        send(6'b000010, 32'd1, 32'd2);
        send(6'b001000, 32'hF0F0F0F0, 32'h0F0F0F0F);
        bus.alu_op    = 6'b000110;
        bus.operand_a = 32'd10;
        bus.operand_b = 32'd3;
        for (int k = 0; k < 3; k++) begin
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_hold_result", bus.alu_result, 32'd3);
            cycle();
            chk("bp_not_accepted", {31'd0, last_acc}, 32'd0);
        end
        chk("bp_sb_depth", 32'(sb.size()), 32'd2);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (last_acc) break;
        end
        chk("bp_third_accepted", {31'd0, last_acc}, 32'd1);
        drain();

        // 5: illegal op then legal op
        chk_lat = 1'b1;
        send(6'b111111, 32'd5, 32'd3);
        send(6'b000010, 32'd5, 32'd3);
        drain();
        chk_lat = 1'b0;

        // 6: async reset with two ops in flight
        bus.rsp_ready = 1'b0;
        send(6'b000010, 32'd7, 32'd8);
        send(6'b000101, 32'h1, 32'h2);
        idle();
        chk("pre_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        sb.delete();
        @(negedge clk);
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("post_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe_unit.md
Name: alu_pipe_unit

Overview:
- Two-stage pipelined ALU execution unit; the responder end of the operand_a / operand_b / alu_op request interface.
- Accepts one operation per cycle through a valid/ready request channel and returns alu_result plus flags on a valid/ready response channel.
- Low-power: operand registers load only on accepted requests (operand isolation); a busy output drives the core's clock-gate enable.
- Sits between issue logic and writeback in the core datapath.

Parameters:
- XLEN, 32, operand/result width.
- OP_W, 6, alu_op width.
- SHAMT_W, 5, shift-amount bits taken from operand_b[SHAMT_W-1:0] (must equal log2(XLEN)).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- operand_a  input  XLEN  first operand.
- operand_b  input  XLEN  second operand / shift amount.
- alu_op  input  OP_W  operation code.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response this cycle.
- alu_result  output  XLEN  registered result.
- zero  output  1  alu_result == 0.
- overflow  output  1  signed overflow, ADD/SUB only.
- illegal_op  output  1  alu_op was not a defined encoding.
- busy  output  1  s1_valid | s2_valid.

Behaviour:
- Reset: async on rst_n low; clears s1_valid, s2_valid, all operand and result registers, and all flags. Outputs during and after reset: req_ready=1, rsp_valid=0, alu_result=0, zero=0, overflow=0, illegal_op=0, busy=0. Reset mid-operation drops all in-flight operations with no response.
- Opcodes:
  - ADD 000010, SUB 000110, AND 000111, OR 000101, XOR 001000.
  - SLL 000100, SRL 000011, SRA 001011.
  - SLT 001100 (signed), SLTU 001101 (unsigned); both give a result of 0 or 1.
  - Any other value: result 0, illegal_op=1.
- Stage 1 (S1): on req_valid & req_ready, latches operand_a, operand_b, alu_op and sets s1_valid. The S1 data registers are not written otherwise.
- Stage 2 (S2): when S1 advances, computes the result combinationally from the S1 registers and latches result, zero, overflow and illegal_op; sets s2_valid.
- Advance rules:
  - s2_free = !s2_valid | rsp_ready.
  - S1 advances into S2 when s1_valid & s2_free.
  - req_ready = !s1_valid | s2_free (combinational; depends on rsp_ready).
  - s1_valid next = accept ? 1 : (advance ? 0 : s1_valid).
  - s2_valid next = advance ? 1 : (rsp_ready ? 0 : s2_valid).
- Latency and throughput: request accepted at edge N gives rsp_valid=1 after edge N+1. Throughput is 1 op/cycle with rsp_ready held high.
- Stall: while rsp_valid=1 and rsp_ready=0, alu_result and all flags hold stable. After the S1 entry fills, req_ready drops and at most 2 operations are held.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN. 7FFFFFFF+1 = 80000000 with overflow=1; 0-1 = FFFFFFFF with overflow=0.
  - Shifts use operand_b[SHAMT_W-1:0] only; upper bits are ignored.
  - SRA sign-extends.
- zero is computed from the final result, including for illegal ops (illegal op gives zero=1).
- Simultaneous events: response accepted and new request accepted in the same cycle pipeline without a bubble.

Test Plan:
1. Reset, then a back-to-back stream with rsp_ready=1: ADD 100+50, SUB 100-50, AND FFFF0000&0000FFFF, OR FFFF0000|0000FFFF -> responses 150, 50, 00000000 (zero=1), FFFFFFFF on consecutive cycles, first response one edge after its accept.
2. Corner arithmetic: ADD 7FFFFFFF+1 -> 80000000, overflow=1. SUB 0-1 -> FFFFFFFF, overflow=0. SLT 80000000,1 -> 1. SLTU 80000000,1 -> 0.
3. Shifts:
   - SLL 1 by 5 -> 00000020.
   - SRL 20 by 5 -> 1.
   - SRA 80000000 by 4 -> F8000000.
   - SLL 1 by operand_b=00000025 -> 00000020 (only low 5 bits used).
4. Backpressure: hold rsp_ready=0 and issue 3 requests -> 2 accepted, req_ready=0 on the 3rd, alu_result stable. Release rsp_ready -> all 3 results emerge in order with none lost or duplicated.
5. alu_op=111111, operands 5,3 -> result 0, illegal_op=1, zero=1. The next legal ADD 5+3 -> 8 with illegal_op=0.
6. Assert rst_n low asynchronously with 2 ops in flight -> rsp_valid=0 and busy=0 immediately, and no stale response after reset release.
